// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the cache / memory-controller / RAM boundary.
//   word_t      : 32-bit bus word (addresses and data).
//   ramstate_t  : RAM handshake state reported by the RAM model or FPGA
//                 RAM wrapper (FREE, BUSY, ACCESS, ERROR).
//   ram_done()  : true when the RAM reports the end of an access, either
//                 successfully (ACCESS) or with a fault (ERROR).
// ---------------------------------------------------------------------------
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  function automatic logic ram_done(ramstate_t s);
    return (s == ACCESS) || (s == ERROR);
  endfunction

endpackage

// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
// Single-core memory controller. Serialises the icache fetch port and the
// dcache read/write port onto one shared RAM port. Data requests have
// priority; a saturating starvation counter forces an instruction fetch
// through after STARVE_LIMIT consecutive data grants made while a fetch
// was pending. Coherence outputs are tied inactive (one core).
//
// Parameters
//   STARVE_LIMIT : data grants tolerated while iREN is pending (1..7)
// Ports
//   CLK, nRST               clock, synchronous active-low reset
//   iREN, iaddr             icache read request / word address
//   iwait, iload            icache stall / fetched instruction
//   dREN, dWEN, daddr,      dcache read / write request, address and
//   dstore                  write data
//   dwait, dload            dcache stall / read data
//   ccwait, ccinv,          coherence outputs, constant 0
//   ccsnoopaddr
//   ramREN, ramWEN,         RAM strobes, address and write data
//   ramaddr, ramstore       (registered, driven from the grant latches)
//   ramload, ramstate       RAM read data and handshake state
//   memerr                  sticky: an access finished with ERROR
// ---------------------------------------------------------------------------
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  // icache side
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  // dcache side
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  // coherence (inactive in a single-core build)
  output logic      ccwait,
  output logic      ccinv,
  output word_t     ccsnoopaddr,
  // RAM side
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  // status
  output logic      memerr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DREAD  = 2'd2,
    DWRITE = 2'd3
  } state_t;

  localparam logic [2:0] LIMIT3 = 3'(STARVE_LIMIT);

  state_t     state;
  logic [2:0] starve_cnt;
  logic       done;
  logic       err_done;
  logic       i_done;
  logic       d_done;

  function automatic logic [2:0] sat_inc(logic [2:0] c);
    return (c >= LIMIT3) ? LIMIT3 : c + 3'd1;
  endfunction

  // A busy state finishes when the RAM reports ACCESS or ERROR. FREE is
  // treated like BUSY. While nRST is low the transaction is being
  // abandoned, so no completion pulse may reach the caches.
  assign done     = nRST && (state != IDLE) && ram_done(ramstate);
  assign err_done = done && (ramstate == ERROR);
  assign i_done   = done && (state == IFETCH);
  assign d_done   = done && ((state == DREAD) || (state == DWRITE));

  // Waits drop combinationally only for the owner in its completion cycle;
  // load data is zero everywhere else and on an ERROR completion.
  assign iwait = !i_done;
  assign dwait = !d_done;
  assign iload = (i_done && !err_done) ? ramload : '0;
  assign dload = (d_done && !err_done) ? ramload : '0;

  assign ccwait      = 1'b0;
  assign ccinv       = 1'b0;
  assign ccsnoopaddr = '0;

  // Arbitration and grant latching (IDLE -> busy) / completion (busy -> IDLE)
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      memerr     <= 1'b0;
      ramREN     <= 1'b0;
      ramWEN     <= 1'b0;
      ramaddr    <= '0;
      ramstore   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iREN && (starve_cnt == LIMIT3)) begin
            // Starvation guard overrides data priority.
            state      <= IFETCH;
            ramREN     <= 1'b1;
            ramaddr    <= iaddr;
            starve_cnt <= '0;
          end else if (dWEN) begin
            state    <= DWRITE;
            ramWEN   <= 1'b1;
            ramaddr  <= daddr;
            ramstore <= dstore;
            if (iREN) starve_cnt <= sat_inc(starve_cnt);
          end else if (dREN) begin
            state   <= DREAD;
            ramREN  <= 1'b1;
            ramaddr <= daddr;
            if (iREN) starve_cnt <= sat_inc(starve_cnt);
          end else if (iREN) begin
            state      <= IFETCH;
            ramREN     <= 1'b1;
            ramaddr    <= iaddr;
            starve_cnt <= '0;
          end
        end
        default: begin
          // Strobes stay up until the RAM finishes, even if the cache
          // has withdrawn its request in the meantime.
          if (done) begin
            state  <= IDLE;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            if (err_done) memerr <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_arbiter
// Scoreboard bench: a transaction-level arbiter model pushes each grant into
// an expectation queue; a monitor pops an entry whenever the DUT drops a
// wait and compares owner, address, write data and returned load. A small
// RAM model answers reads from a sparse memory and absorbs writes.
// ---------------------------------------------------------------------------
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int LIMIT = 4;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ccwait;
  logic      ccinv;
  word_t     ccsnoopaddr;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload = '0;
  ramstate_t ramstate;
  logic      memerr;

  always #5 CLK = ~CLK;

  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .memerr(memerr)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // kind: 0 = instruction fetch, 1 = data read, 2 = data write
  typedef struct {
    int    kind;
    word_t addr;
    word_t data;
  } txn_t;

  txn_t  exp_q[$];
  txn_t  cur;
  bit    cur_busy = 0;
  int    starve   = 0;
  bit    err_m    = 0;
  bit    mon_on   = 0;
  word_t mem_m[word_t];
  word_t mem_r[word_t];

  function automatic word_t seed_val(word_t a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic word_t mread(word_t a);
    return mem_m.exists(a) ? mem_m[a] : seed_val(a);
  endfunction

  function automatic word_t rread(word_t a);
    return mem_r.exists(a) ? mem_r[a] : seed_val(a);
  endfunction

  // RAM model: read data settles shortly after the edge, writes land
  // after the monitor has looked at the cycle.
  always @(posedge CLK) begin
    #2;
    ramload = rread(ramaddr);
  end

  always @(negedge CLK) begin
    #1;
    if (nRST && ramWEN && ramstate == ACCESS) mem_r[ramaddr] = ramstore;
  end

  // Reference arbiter: one transaction at a time, priority rules with a
  // pending-fetch starvation tally, one idle arbitration slot after each
  // completion.
  always @(posedge CLK) begin
    if (!nRST) begin
      exp_q.delete();
      cur_busy = 0;
      starve   = 0;
      err_m    = 0;
    end else if (cur_busy) begin
      if (ramstate == ACCESS || ramstate == ERROR) begin
        total++;
        if (exp_q.size() != 0) begin
          bad++;
          $display("FAIL no_completion actual=none required=kind%0d", cur.kind);
          exp_q.delete();
        end
        if (ramstate == ERROR) err_m = 1;
        else if (cur.kind == 2) mem_m[cur.addr] = cur.data;
        cur_busy = 0;
      end
    end else begin
      int k;
      k = -1;
      if (iREN && starve == LIMIT) k = 0;
      else if (dWEN)               k = 2;
      else if (dREN)               k = 1;
      else if (iREN)               k = 0;
      if (k == 0) starve = 0;
      else if (k > 0 && iREN && starve < LIMIT) starve++;
      if (k >= 0) begin
        cur.kind = k;
        cur.addr = (k == 0) ? iaddr : daddr;
        cur.data = dstore;
        cur_busy = 1;
        exp_q.push_back(cur);
      end
    end
  end

  // Monitor: compares strobes against the in-flight transaction and pops
  // the expectation queue whenever a wait goes low.
  always @(negedge CLK) begin
    if (mon_on) begin
      bit   comp;
      txn_t t;
      comp = nRST && cur_busy && (ramstate == ACCESS || ramstate == ERROR);
      chk("memerr", memerr, err_m);
      chk("ccwait", ccwait, 0);
      chk("ccinv", ccinv, 0);
      chk("ccsnoopaddr", ccsnoopaddr, 0);
      if (cur_busy) begin
        chk("ramREN", ramREN, cur.kind != 2);
        chk("ramWEN", ramWEN, cur.kind == 2);
        chk("ramaddr", ramaddr, cur.addr);
        if (cur.kind == 2) chk("ramstore", ramstore, cur.data);
      end else begin
        chk("ramREN_idle", ramREN, 0);
        chk("ramWEN_idle", ramWEN, 0);
      end
      if (!iwait || !dwait) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done actual=iwait%0b_dwait%0b required=none", iwait, dwait);
        end else begin
          t = exp_q.pop_front();
          chk("early_done", comp, 1);
          chk("iwait_owner", iwait, t.kind != 0);
          chk("dwait_owner", dwait, t.kind == 0);
          chk("load", (t.kind == 0) ? iload : dload,
              (ramstate == ERROR) ? 32'h0 : mread(t.addr));
          chk("other_load", (t.kind == 0) ? dload : iload, 0);
        end
      end else begin
        chk("missing_done", comp, 0);
        chk("iload_stall", iload, 0);
        chk("dload_stall", dload, 0);
      end
    end
  end

  // One cycle of input values, applied just after the active edge.
  task automatic drive(bit rn, bit ir, word_t ia, bit dr, bit dw,
                       word_t da, word_t ds, ramstate_t rs);
    nRST     = rn;
    iREN     = ir;
    iaddr    = ia;
    dREN     = dr;
    dWEN     = dw;
    daddr    = da;
    dstore   = ds;
    ramstate = rs;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1, 0, 0, 0, 0, 0, 0, FREE);
  endtask

  initial begin
    nRST = 0; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0;
    daddr = 0; dstore = 0; ramstate = FREE;
    @(posedge CLK); #1;
    @(posedge CLK); #1;

    // reset values
    chk("rst_iwait", iwait, 1);
    chk("rst_dwait", dwait, 1);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_memerr", memerr, 0);
    chk("rst_cc", {ccwait, ccinv}, 0);
    mon_on = 1;

    // solo fetch with two BUSY cycles
    mem_r[32'h40] = 32'h8C220004;
    mem_m[32'h40] = 32'h8C220004;
    drive(1, 1, 32'h40, 0, 0, 0, 0, FREE);
    drive(1, 1, 32'h40, 0, 0, 0, 0, BUSY);
    drive(1, 1, 32'h40, 0, 0, 0, 0, BUSY);
    drive(1, 1, 32'h40, 0, 0, 0, 0, ACCESS);
    idle(2);

    // write beats fetch raised in the same cycle, fetch follows
    drive(1, 1, 32'h44, 0, 1, 32'h100, 32'hDEADBEEF, FREE);
    drive(1, 1, 32'h44, 0, 1, 32'h100, 32'hDEADBEEF, ACCESS);
    drive(1, 1, 32'h44, 0, 0, 32'h100, 32'hDEADBEEF, FREE);
    drive(1, 1, 32'h44, 0, 0, 32'h100, 32'hDEADBEEF, ACCESS);
    idle(2);

    // starvation: fetch pending while reads keep coming
    repeat (20) drive(1, 1, 32'h48, 1, 0, 32'h100, 0, ACCESS);
    idle(2);

    // error completion, memerr sticky
    drive(1, 0, 0, 1, 0, 32'h80, 0, FREE);
    drive(1, 0, 0, 1, 0, 32'h80, 0, ERROR);
    idle(4);

    // reset in the middle of a write
    drive(1, 0, 0, 0, 1, 32'h90, 32'h1234, FREE);
    drive(1, 0, 0, 0, 1, 32'h90, 32'h1234, BUSY);
    drive(0, 0, 0, 0, 1, 32'h90, 32'h1234, BUSY);
    idle(3);

    // address changes while a read is outstanding
    drive(1, 0, 0, 1, 0, 32'h200, 0, FREE);
    drive(1, 0, 0, 1, 0, 32'h300, 0, BUSY);
    drive(1, 0, 0, 1, 0, 32'h300, 0, BUSY);
    drive(1, 0, 0, 1, 0, 32'h300, 0, ACCESS);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int        r;
      ramstate_t rs;
      r = $urandom_range(0, 99);
      if (r < 15)      rs = FREE;
      else if (r < 50) rs = BUSY;
      else if (r < 92) rs = ACCESS;
      else             rs = ERROR;
      drive($urandom_range(0, 199) != 0,
            $urandom_range(0, 9) < 7, {26'($urandom_range(0, 15)), 6'h0},
            $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3,
            {26'($urandom_range(0, 15)), 6'h0}, $urandom, rs);
    end
    idle(4);

    mon_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
